alu: RTL and testbench

- Registered W-bit integer ALU for the pipelined processor's execute stage.
- Takes two operands and a 4-bit opcode, and produces a result plus carry, zero and negative flags.
- Result and flags are registered: they appear one clock after the operands and opcode are applied.
- The flags form a persistent condition-code register that each opcode updates selectively.

---
 rtl/alu_if.sv | 8 +
 rtl/alu.sv | 56 +++++
 tb/tb_alu.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// alu_if: operand/opcode inputs and registered result/flag outputs of the execute-stage ALU.
interface alu_if #(parameter int W = 16);
    logic [W-1:0] in1, in2, result;
    logic [3:0] controlSignal;
    logic carry, zero, neg;
    modport master(output in1, in2, controlSignal, input result, carry, zero, neg);
    modport slave(input in1, in2, controlSignal, output result, carry, zero, neg);
endinterface

// File: rtl/alu.sv
// alu: registered W-bit ALU whose carry/zero/neg condition codes are updated selectively per opcode.
module alu #(parameter int W = 16) (
    input logic clk,
    input logic rst,
    alu_if.slave io
);
    localparam int SW = $clog2(W);
    localparam logic [W:0] ONE = (W+1)'(1);
    logic [W-1:0] a, b, nr;
    logic [SW-1:0] s;
    logic [W:0] shl, shr;
    logic nc, zn;
    assign a = io.in1;
    assign b = io.in2;
    assign s = io.in2[SW-1:0];
    // shr carries A[s-1] into bit 0 by shifting a zero-padded copy
    assign shl = {1'b0, a} << s;
    assign shr = {a, 1'b0} >> s;
    always_comb begin
        nr = io.result;
        nc = io.carry;
        zn = 1'b1;
        case (io.controlSignal)
            4'd0: begin nr = a; zn = 1'b0; end
            4'd1: {nc, nr} = {1'b0, b} + ONE;
            4'd2: {nc, nr} = {1'b0, a} + ONE;
            4'd3: {nc, nr} = {1'b0, a} - ONE;
            4'd4: nr = ~a;
            4'd5: {nc, nr} = {1'b0, a} + {1'b0, b};
            4'd6: {nc, nr} = {1'b0, a} - {1'b0, b};
            4'd7: nr = a & b;
            4'd8: nr = a | b;
            4'd9: begin nc = 1'b1; zn = 1'b0; end
            4'd10: begin nc = 1'b0; zn = 1'b0; end
            4'd11: begin nr = shl[W-1:0]; nc = (s == '0) ? io.carry : shl[W]; end
            4'd12: begin nr = shr[W:1]; nc = (s == '0) ? io.carry : shr[0]; end
            4'd13: begin nr = b; zn = 1'b0; end
            default: zn = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            io.result <= '0;
            io.carry <= 1'b0;
            io.zero <= 1'b0;
            io.neg <= 1'b0;
        end else begin
            io.result <= nr;
            io.carry <= nc;
            if (zn) begin
                io.zero <= (nr == '0);
                io.neg <= nr[W-1];
            end
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random vectors against an arithmetic model, plus literal pins from hand-computed values.
module tb_alu;
    localparam int W = 16;
    localparam longint M = longint'(1) << W;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    bit valid = 0;
    longint m_res = 0;
    bit m_c = 0, m_z = 0, m_n = 0;

    alu_if #(.W(W)) io();
    alu #(.W(W)) dut(.clk(clk), .rst(rst), .io(io.slave));

    always #5 clk = ~clk;

    function automatic void model(input int op, input longint a, input longint b,
                                  inout longint r, inout bit c, output bit upd);
        int s;
        s = int'(b % W);
        upd = 1;
        case (op)
            0: begin r = a; upd = 0; end
            1: begin c = (b + 1) >= M; r = (b + 1) % M; end
            2: begin c = (a + 1) >= M; r = (a + 1) % M; end
            3: begin c = (a == 0); r = (a + M - 1) % M; end
            4: r = M - 1 - a;
            5: begin c = (a + b) >= M; r = (a + b) % M; end
            6: begin c = a < b; r = (a - b + M) % M; end
            7: r = a & b;
            8: r = a | b;
            9: begin c = 1; upd = 0; end
            10: begin c = 0; upd = 0; end
            11: begin if (s != 0) c = ((a * (longint'(1) << s)) / M) % 2 == 1; r = (a * (longint'(1) << s)) % M; end
            12: begin if (s != 0) c = (a / (longint'(1) << (s - 1))) % 2 == 1; r = a / (longint'(1) << s); end
            13: begin r = b; upd = 0; end
            default: upd = 0;
        endcase
    endfunction

    always @(posedge clk) begin
        longint r;
        bit c, u;
        r = m_res;
        c = m_c;
        model(int'(io.controlSignal), longint'(io.in1), longint'(io.in2), r, c, u);
        valid <= 1;
        if (rst) begin
            m_res <= 0; m_c <= 0; m_z <= 0; m_n <= 0;
        end else begin
            m_res <= r;
            m_c <= c;
            if (u) begin
                m_z <= (r == 0);
                m_n <= (r >= M / 2);
            end
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            checks++;
            if (longint'(io.result) != m_res || io.carry != m_c || io.zero != m_z || io.neg != m_n) begin
                errors++;
                $display("FAIL model op=%0d: got r=%h c=%b z=%b n=%b, want r=%h c=%b z=%b n=%b",
                         io.controlSignal, io.result, io.carry, io.zero, io.neg, m_res[W-1:0], m_c, m_z, m_n);
            end
        end
    end

    task automatic step(input bit r, input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        rst = r;
        io.controlSignal = 4'(op);
        io.in1 = a;
        io.in2 = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pin(input string name, input logic [W-1:0] r, input bit c, input bit z, input bit n);
        checks++;
        if (io.result !== r || io.carry !== c || io.zero !== z || io.neg !== n) begin
            errors++;
            $display("FAIL %s: got r=%h c=%b z=%b n=%b, want r=%h c=%b z=%b n=%b",
                     name, io.result, io.carry, io.zero, io.neg, r, c, z, n);
        end
    endtask

    initial begin
        rst = 1;
        io.controlSignal = 4'd5;
        io.in1 = 16'h1234;
        io.in2 = 16'h4321;
        step(1, 5, 16'hFFFF, 16'hFFFF);    pin("reset", 16'h0000, 0, 0, 0);
        step(0, 0, 16'h0001, 16'h0000);    pin("passa", 16'h0001, 0, 0, 0);
        step(0, 5, 16'hFFFF, 16'hFFFB);    pin("add", 16'hFFFA, 1, 0, 1);
        step(0, 1, 16'h0000, 16'hFFFF);    pin("incb_wrap", 16'h0000, 1, 1, 0);
        step(0, 2, 16'd20, 16'd0);         pin("inca20", 16'd21, 0, 0, 0);
        step(0, 2, 16'd5, 16'd0);          pin("inca5", 16'd6, 0, 0, 0);
        step(0, 3, 16'd10, 16'd0);         pin("deca10", 16'd9, 0, 0, 0);
        step(0, 3, 16'd0, 16'd0);          pin("deca0", 16'hFFFF, 1, 0, 1);
        step(0, 4, 16'd100, 16'd0);        pin("nota", 16'hFF9B, 1, 0, 1);
        step(0, 6, 16'd3, 16'd10);         pin("sub_borrow", 16'hFFF9, 1, 0, 1);
        step(0, 6, 16'd10, 16'd3);         pin("sub", 16'h0007, 0, 0, 0);
        step(0, 9, 16'd0, 16'd0);          pin("setc_pre", 16'h0007, 1, 0, 0);
        step(0, 7, 16'd10, 16'd5);         pin("and", 16'h0000, 1, 1, 0);
        step(0, 8, 16'd10, 16'd5);         pin("or", 16'h000F, 1, 0, 0);
        step(0, 10, 16'd10, 16'd5);        pin("clrc", 16'h000F, 0, 0, 0);
        step(0, 9, 16'd10, 16'd5);         pin("setc", 16'h000F, 1, 0, 0);
        step(0, 10, 16'd10, 16'd5);        pin("clrc2", 16'h000F, 0, 0, 0);
        step(0, 11, 16'd10, 16'd5);        pin("shl", 16'h0140, 0, 0, 0);
        step(0, 12, 16'd10, 16'd5);        pin("shr", 16'h0000, 0, 1, 0);
        step(0, 12, 16'h0010, 16'd5);      pin("shr_carry", 16'h0000, 1, 1, 0);
        step(0, 11, 16'h1234, 16'd0);      pin("shl_s0", 16'h1234, 1, 0, 0);
        step(0, 11, 16'h8001, 16'hFFF1);   pin("shl_upper_b", 16'h0002, 1, 0, 0);
        step(0, 10, 16'd0, 16'd0);         pin("clrc3", 16'h0002, 0, 0, 0);
        step(0, 12, 16'h8001, 16'h0020);   pin("shr_s0_upper", 16'h8001, 0, 0, 1);
        step(0, 11, 16'h8000, 16'd15);     pin("shl15", 16'h0000, 0, 1, 0);
        step(0, 13, 16'd0, 16'h8000);      pin("passb", 16'h8000, 0, 1, 0);
        step(0, 14, 16'h1111, 16'h2222);   pin("nop14", 16'h8000, 0, 1, 0);
        step(0, 15, 16'h3333, 16'h4444);   pin("nop15", 16'h8000, 0, 1, 0);
        step(1, 9, 16'h5555, 16'h6666);    pin("rst_mid", 16'h0000, 0, 0, 0);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 39) == 0, int'($urandom_range(0, 15)),
                 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 16'($urandom));
        step(0, 3, 16'd0, 16'd0);          pin("deca0_end", 16'hFFFF, 1, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
